// File: rtl/sci_link_ctrl_if.sv
// sci_bus_if: internal-bus master port of the SCI link sequencer
interface sci_bus_if;
  logic [31:0] M_A;
  logic [31:0] M_DO;
  logic [31:0] M_DI;
  logic [3:0]  M_BA;
  logic        M_WE;
  logic        M_REQ;
  logic        M_BUSY;
  modport master (output M_A, M_DO, M_BA, M_WE, M_REQ, input M_DI, M_BUSY);
  modport slave  (input M_A, M_DO, M_BA, M_WE, M_REQ, output M_DI, M_BUSY);
endinterface

// File: rtl/sci_link_ctrl.sv
// sci_link_ctrl: bus-master sequencer that inits the SCI and shuttles TX/RX bytes by polling SSR
module sci_link_ctrl #(
  parameter logic [31:0] BASE    = 32'hFFFFFE00,
  parameter logic [7:0]  SMR_VAL = 8'h00,
  parameter logic [7:0]  BRR_VAL = 8'h00,
  parameter logic [7:0]  SCR_VAL = 8'h30
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic       EN,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic [7:0] OVR_CNT,
  sci_bus_if.master  bus
);
  typedef enum logic [3:0] {
    OFF, INIT_SMR, INIT_BRR, INIT_SCR, POLL, POLL_WAIT, DISPATCH,
    TX_TDR, TX_SSR, RX_RD, RX_WAIT, RX_SSR, ER_CLR, SHUT
  } state_t;
  state_t      st, nxt;
  logic [2:0]  s;
  logic [7:0]  hold;
  logic        full, last_rx;
  logic        done, rx_c, tx_c, pick_rx;
  logic        n_req, n_we;
  logic [2:0]  n_off;
  logic [7:0]  n_dat;
  logic [31:0] n_a;
  logic        unused_di;
  assign unused_di = ^{bus.M_DI[28:24], bus.M_DI[15:0]};
  assign done      = !bus.M_BUSY;
  assign TX_READY  = !full;
  // s holds SSR[7:5] = {TDRE, RDRF, ORER}
  assign rx_c      = s[1] & !RX_VALID;
  assign tx_c      = s[2] & full;
  assign pick_rx   = rx_c & (!tx_c | !last_rx);
  always_comb begin
    nxt = st;
    case (st)
      OFF:                              nxt = EN ? INIT_SMR : OFF;
      INIT_SMR:                         nxt = done ? INIT_BRR : st;
      INIT_BRR:                         nxt = done ? INIT_SCR : st;
      INIT_SCR, TX_SSR, RX_SSR, ER_CLR: nxt = done ? POLL : st;
      POLL:                             nxt = done ? POLL_WAIT : st;
      POLL_WAIT:                        nxt = DISPATCH;
      DISPATCH:                         nxt = !EN ? SHUT : s[0] ? ER_CLR : pick_rx ? RX_RD : tx_c ? TX_TDR : POLL;
      TX_TDR:                           nxt = done ? TX_SSR : st;
      RX_RD:                            nxt = done ? RX_WAIT : st;
      RX_WAIT:                          nxt = RX_SSR;
      SHUT:                             nxt = done ? OFF : st;
      default:                          nxt = OFF;
    endcase
  end
  // bus outputs are registered from the state being entered
  always_comb begin
    n_req = 1'b1;
    n_we  = 1'b1;
    n_off = 3'd4;
    n_dat = 8'h00;
    case (nxt)
      INIT_SMR: begin n_off = 3'd0; n_dat = SMR_VAL; end
      INIT_BRR: begin n_off = 3'd1; n_dat = BRR_VAL; end
      INIT_SCR, SHUT: begin n_off = 3'd2; n_dat = (nxt == SHUT) ? 8'h00 : SCR_VAL; end
      TX_TDR:   begin n_off = 3'd3; n_dat = hold; end
      TX_SSR:   n_dat = 8'h7E;
      RX_SSR:   n_dat = 8'hBE;
      ER_CLR:   n_dat = 8'hDE;
      POLL:     n_we = 1'b0;
      RX_RD:    begin n_we = 1'b0; n_off = 3'd5; end
      default:  begin n_req = 1'b0; n_we = 1'b0; end
    endcase
    n_a = BASE + {29'd0, n_off};
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st         <= OFF;
      s          <= 3'd0;
      hold       <= 8'h00;
      full       <= 1'b0;
      last_rx    <= 1'b0;
      RX_DATA    <= 8'h00;
      RX_VALID   <= 1'b0;
      OVR_CNT    <= 8'h00;
      bus.M_REQ  <= 1'b0;
      bus.M_WE   <= 1'b0;
      bus.M_A    <= 32'h0;
      bus.M_DO   <= 32'h0;
      bus.M_BA   <= 4'h0;
    end else if (CE) begin
      st        <= nxt;
      bus.M_REQ <= n_req;
      bus.M_WE  <= n_we;
      if (n_req) begin
        bus.M_A  <= n_a;
        bus.M_DO <= {4{n_dat}};
        bus.M_BA <= 4'b1000 >> n_a[1:0];
      end
      if (st == POLL_WAIT) s <= bus.M_DI[31:29];
      if (st == RX_WAIT) RX_DATA <= bus.M_DI[23:16];
      if (TX_VALID && !full) begin
        hold <= TX_DATA;
        full <= 1'b1;
      end else if (st == TX_SSR && done) full <= 1'b0;
      if (st == RX_SSR && done) RX_VALID <= 1'b1;
      else if (RX_READY) RX_VALID <= 1'b0;
      if (st == ER_CLR && done && OVR_CNT != 8'hFF) OVR_CNT <= OVR_CNT + 8'd1;
      if (st == DISPATCH && (nxt == RX_RD || nxt == TX_TDR)) last_rx <= (nxt == RX_RD);
    end
  end
endmodule

// File: tb/tb_sci_link_ctrl.sv
// tb_sci_link_ctrl: directed bench with a small SCI register model on the bus
module tb_sci_link_ctrl;
  logic       clk = 0, rst_n = 1, ce = 1, en = 0;
  logic [7:0] tx_data = 0, rx_data, ovr_cnt;
  logic       tx_valid = 0, tx_ready, rx_valid, rx_ready = 0;
  logic [7:0] ssr = 0, rdr = 0;
  logic       sticky = 0;
  int         vec = 0, err = 0;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] ba;} wr_t;
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  logic [7:0]  svc_q[$];

  sci_bus_if bus();
  sci_link_ctrl dut (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .EN(en),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready),
    .OVR_CNT(ovr_cnt), .bus(bus.master)
  );

  always #5 clk = ~clk;
  assign bus.M_DI = {4{(bus.M_A == 32'hFFFFFE05) ? rdr : ssr}};

  // SCI model: completed accesses are logged; SSR writes clear flags written as 0
  always @(posedge clk)
    if (rst_n && ce && bus.M_REQ && !bus.M_BUSY) begin
      if (bus.M_WE) begin
        wr_q.push_back({bus.M_A, bus.M_DO, bus.M_BA});
        if (bus.M_A == 32'hFFFFFE03) svc_q.push_back("T");
        if (bus.M_A == 32'hFFFFFE04 && !sticky) ssr = ssr & bus.M_DO[7:0];
      end else begin
        rd_q.push_back(bus.M_A);
        if (bus.M_A == 32'hFFFFFE05) svc_q.push_back("R");
      end
    end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input logic [31:0] a, output logic hit);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      hit = bus.M_REQ && bus.M_A == a;
    end
  endtask

  task automatic wait_tx_ready(output logic ok);
    ok = tx_ready;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = tx_ready;
    end
  endtask

  task automatic push(input logic [7:0] b, output logic ok);
    tx_data = b;
    tx_valid = 1;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      ok = tx_ready;
    end
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    cycles(2);
    vec++;
    if ({tx_ready, rx_valid, rx_data, ovr_cnt, bus.M_REQ, bus.M_WE, bus.M_A, bus.M_DO, bus.M_BA} !==
        {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
      err++;
      $display("FAIL reset_values: got rdy=%b rv=%b rd=%h ovr=%h req=%b we=%b a=%h do=%h ba=%b", tx_ready, rx_valid, rx_data, ovr_cnt, bus.M_REQ, bus.M_WE, bus.M_A, bus.M_DO, bus.M_BA);
    end
  endtask

  task automatic test_init;
    ce = 0;
    en = 1;
    rst_n = 1;
    cycles(5);
    vec++;
    if (bus.M_REQ !== 1'b0) begin err++; $display("FAIL ce_gate: req=%b want 0", bus.M_REQ); end
    ce = 1;
    cycles(30);
    vec++;
    if (wr_q[0] !== {32'hFFFFFE00, 32'h00000000, 4'b1000}) begin err++; $display("FAIL init_smr: got %h want fffffe00_00000000_8", wr_q[0]); end
    vec++;
    if (wr_q[1] !== {32'hFFFFFE01, 32'h00000000, 4'b0100}) begin err++; $display("FAIL init_brr: got %h want fffffe01_00000000_4", wr_q[1]); end
    vec++;
    if (wr_q[2] !== {32'hFFFFFE02, 32'h30303030, 4'b0010}) begin err++; $display("FAIL init_scr: got %h want fffffe02_30303030_2", wr_q[2]); end
    vec++;
    if (wr_q.size() != 3 || rd_q[0] !== 32'hFFFFFE04) begin err++; $display("FAIL init_poll: writes=%0d rd0=%h want 3 fffffe04", wr_q.size(), rd_q[0]); end
  endtask

  task automatic test_tx;
    logic ok;
    wr_q.delete();
    push(8'hA5, ok);
    vec++;
    if (!ok || tx_ready !== 1'b0) begin err++; $display("FAIL tx_accept: ok=%b rdy=%b want 1 0", ok, tx_ready); end
    ssr = 8'h84;
    wait_tx_ready(ok);
    vec++;
    if (!ok) begin err++; $display("FAIL tx_ready_return: rdy=%b want 1", tx_ready); end
    vec++;
    if (wr_q.size() != 2 || wr_q[0] !== {32'hFFFFFE03, 32'hA5A5A5A5, 4'b0001} || wr_q[1] !== {32'hFFFFFE04, 32'h7E7E7E7E, 4'b1000}) begin
      err++;
      $display("FAIL tx_writes: n=%0d w0=%h w1=%h want 2 fffffe03_a5a5a5a5_1 fffffe04_7e7e7e7e_8", wr_q.size(), wr_q[0], wr_q[1]);
    end
  endtask

  task automatic test_rx;
    logic ok;
    wr_q.delete();
    rx_ready = 0;
    rdr = 8'h3C;
    ssr = 8'h40;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk); ok = rx_valid; end
    vec++;
    if (!ok || rx_data !== 8'h3C) begin err++; $display("FAIL rx_byte: rv=%b data=%h want 1 3c", rx_valid, rx_data); end
    vec++;
    if (wr_q.size() != 1 || wr_q[0] !== {32'hFFFFFE04, 32'hBEBEBEBE, 4'b1000}) begin err++; $display("FAIL rx_clr: n=%0d w0=%h want 1 fffffe04_bebebebe_8", wr_q.size(), wr_q[0]); end
    svc_q.delete();
    rdr = 8'h55;
    ssr = 8'h40;
    cycles(40);
    vec++;
    if (svc_q.size() != 0 || rx_data !== 8'h3C || rx_valid !== 1'b1) begin err++; $display("FAIL rx_hold: reads=%0d data=%h rv=%b want 0 3c 1", svc_q.size(), rx_data, rx_valid); end
    rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk); ok = rx_valid; end
    vec++;
    if (!ok || rx_data !== 8'h55 || svc_q.size() != 1) begin err++; $display("FAIL rx_after_pop: rv=%b data=%h reads=%0d want 1 55 1", rx_valid, rx_data, svc_q.size()); end
    rx_ready = 1;
    cycles(5);
  endtask

  task automatic test_round_robin;
    logic ok;
    sticky = 1;
    tx_data = 8'h11;
    tx_valid = 1;
    cycles(2);
    svc_q.delete();
    ssr = 8'hC4;
    for (int i = 0; i < 400 && svc_q.size() < 4; i++) @(negedge clk);
    vec++;
    if ({svc_q[0], svc_q[1], svc_q[2], svc_q[3]} !== "TRTR") begin err++; $display("FAIL rr_order: got %s%s%s%s want TRTR", svc_q[0], svc_q[1], svc_q[2], svc_q[3]); end
    tx_valid = 0;
    wait_tx_ready(ok);
    sticky = 0;
    ssr = 8'h04;
    cycles(40);
    wr_q.delete();
    vec++;
    if (!ok || ovr_cnt !== 8'h00) begin err++; $display("FAIL rr_drain: rdy=%b ovr=%h want 1 00", ok, ovr_cnt); end
    ssr = 8'hE4;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk); ok = (ovr_cnt == 8'h01); end
    vec++;
    if (!ok || wr_q[0] !== {32'hFFFFFE04, 32'hDEDEDEDE, 4'b1000}) begin err++; $display("FAIL er_clr: ovr=%h w0=%h want 01 fffffe04_dedededе_8", ovr_cnt, wr_q[0]); end
    cycles(40);
    vec++;
    if (ovr_cnt !== 8'h01) begin err++; $display("FAIL ovr_stable: ovr=%h want 01", ovr_cnt); end
  endtask

  task automatic test_busy;
    logic ok, hit;
    wr_q.delete();
    push(8'h5A, ok);
    ssr = 8'h84;
    wait_req(32'hFFFFFE03, hit);
    vec++;
    if (!ok || !hit) begin err++; $display("FAIL busy_start: push=%b req=%b want 1 1", ok, hit); end
    bus.M_BUSY = 1;
    repeat (3) begin
      @(negedge clk);
      vec++;
      if ({bus.M_REQ, bus.M_WE, bus.M_A, bus.M_DO, bus.M_BA} !== {1'b1, 1'b1, 32'hFFFFFE03, 32'h5A5A5A5A, 4'b0001}) begin
        err++;
        $display("FAIL busy_hold: req=%b we=%b a=%h do=%h ba=%b want 1 1 fffffe03 5a5a5a5a 0001", bus.M_REQ, bus.M_WE, bus.M_A, bus.M_DO, bus.M_BA);
      end
    end
    bus.M_BUSY = 0;
    wait_tx_ready(ok);
    vec++;
    if (!ok || wr_q.size() != 2 || wr_q[0] !== {32'hFFFFFE03, 32'h5A5A5A5A, 4'b0001} || wr_q[1] !== {32'hFFFFFE04, 32'h7E7E7E7E, 4'b1000}) begin
      err++;
      $display("FAIL busy_resume: rdy=%b n=%0d w0=%h w1=%h want 1 2 fffffe03_5a5a5a5a_1 fffffe04_7e7e7e7e_8", ok, wr_q.size(), wr_q[0], wr_q[1]);
    end
  endtask

  task automatic test_shutdown;
    logic ok, hit;
    wr_q.delete();
    push(8'h77, ok);
    ssr = 8'h84;
    wait_req(32'hFFFFFE03, hit);
    en = 0;
    cycles(40);
    vec++;
    if (!hit || wr_q.size() != 3 || wr_q[0] !== {32'hFFFFFE03, 32'h77777777, 4'b0001} || wr_q[1] !== {32'hFFFFFE04, 32'h7E7E7E7E, 4'b1000}) begin
      err++;
      $display("FAIL shut_tx_done: hit=%b n=%0d w0=%h w1=%h want 1 3 fffffe03_77777777_1 fffffe04_7e7e7e7e_8", hit, wr_q.size(), wr_q[0], wr_q[1]);
    end
    vec++;
    if (wr_q[2] !== {32'hFFFFFE02, 32'h00000000, 4'b0010}) begin err++; $display("FAIL shut_scr: got %h want fffffe02_00000000_2", wr_q[2]); end
    rd_q.delete();
    cycles(10);
    vec++;
    if (rd_q.size() != 0 || bus.M_REQ !== 1'b0 || tx_ready !== 1'b1) begin err++; $display("FAIL shut_off: reads=%0d req=%b rdy=%b want 0 0 1", rd_q.size(), bus.M_REQ, tx_ready); end
  endtask

  task automatic test_reset_mid;
    logic ok, hit;
    en = 1;
    push(8'h33, ok);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin @(negedge clk); hit = bus.M_REQ; end
    rst_n = 0;
    #1;
    vec++;
    if (!ok || !hit || {tx_ready, rx_valid, rx_data, ovr_cnt, bus.M_REQ, bus.M_WE, bus.M_A, bus.M_DO, bus.M_BA} !==
        {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
      err++;
      $display("FAIL reset_mid: hit=%b rdy=%b rv=%b rd=%h ovr=%h req=%b a=%h do=%h ba=%b want all reset", hit, tx_ready, rx_valid, rx_data, ovr_cnt, bus.M_REQ, bus.M_A, bus.M_DO, bus.M_BA);
    end
    @(negedge clk);
    rst_n = 1;
    cycles(2);
  endtask

  initial begin
    bus.M_BUSY = 0;
    test_reset;
    test_init;
    test_tx;
    test_rx;
    test_round_robin;
    test_busy;
    test_shutdown;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
